ldpc_sched_ctrl: RTL and testbench

Parametrised iteration scheduler for the LDPC decoder core, replacing the fixed-rate controller. It sequences frame load, CNU and VNU phases, early termination and output drain. It drives the LQ/LR memory read and write strobes and the CNU/VNU cycle phase. It adds selectable code-rate lengths, configurable pipeline latency, a syndrome-based early-exit enable, output backpressure and overrun reporting.

---
 rtl/ldpc_pkg.sv | 31 +++
 rtl/ldpc_phase_gen.sv | 40 ++++
 rtl/ldpc_sched_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ldpc_sched_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared constants for the LDPC iteration scheduler: FSM encodings,
// cycle-phase codes and per-rate output frame lengths.
package ldpc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CNU    = 3'd2,
    S_VNU    = 3'd3,
    S_OUTPUT = 3'd4
  } state_idx_e;

  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_LOAD   = 5'b00010;
  localparam logic [4:0] ST_CNU    = 5'b00100;
  localparam logic [4:0] ST_VNU    = 5'b01000;
  localparam logic [4:0] ST_OUTPUT = 5'b10000;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_1    = 2'd1;
  localparam logic [1:0] PH_2    = 2'd2;
  localparam logic [1:0] PH_3    = 2'd3;

  // Output beats per frame, indexed by the latched code-rate select.
  localparam logic [3:0][12:0] OUT_LEN = {13'd7680, 13'd6912, 13'd5760, 13'd4608};

  function automatic logic [12:0] out_last(input logic [1:0] r);
    return OUT_LEN[r] - 13'd1;
  endfunction

endpackage

// File: rtl/ldpc_phase_gen.sv
// 1-2-3 memory cycle phase generator with a registered strobe on phase 2.
module ldpc_phase_gen
  import ldpc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       last,
  output logic [1:0] phase,
  output logic       strobe
);

  logic [1:0] phase_n_s;

  // Next phase: cycle 1,2,3 while enabled, park at 0 on the last access.
  always_comb begin
    phase_n_s = PH_NONE;
    if (ena && !last) begin
      case (phase)
        PH_1:    phase_n_s = PH_2;
        PH_2:    phase_n_s = PH_3;
        default: phase_n_s = PH_1;
      endcase
    end else begin
      phase_n_s = PH_NONE;
    end
  end

  // Phase and strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= PH_NONE;
      strobe <= 1'b0;
    end else begin
      phase  <= phase_n_s;
      strobe <= (phase == PH_2);
    end
  end

endmodule

// File: rtl/ldpc_sched_ctrl.sv
// LDPC decoder iteration scheduler: frame load, CNU/VNU phases, early exit,
// output drain with backpressure, and overrun reporting.
module ldpc_sched_ctrl
  import ldpc_pkg::*;
#(
  parameter int ITER_W   = 5,
  parameter int CNT_W    = 13,
  parameter int RATE_W   = 2,
  parameter int CNU_LEN  = 768,
  parameter int PIPE_LAT = 7,
  parameter int DRAIN    = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sync_in,
  input  logic [RATE_W-1:0] rate,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              early_term_en,
  input  logic              parity_err,
  input  logic              out_ready,
  output logic [4:0]        fsm_state,
  output logic [3:0]        cycle,
  output logic              rd_lq,
  output logic              rd_lr,
  output logic              wr_lq,
  output logic              wr_lr,
  output logic              iter_0,
  output logic [ITER_W-1:0] num_iter,
  output logic              busy,
  output logic              finish,
  output logic              out_valid,
  output logic              converged,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNU_LAST = CNT_W'(CNU_LEN - 1);
  localparam logic [CNT_W-1:0] VNU_LAST = CNT_W'(CNU_LEN - 1 + DRAIN);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(CNU_LEN - 2 + DRAIN);

  logic [4:0]          state_r, state_n_s;
  logic [CNT_W-1:0]    cnt_r, cnt_n_s;
  logic [RATE_W-1:0]   rate_r;
  logic [ITER_W-1:0]   max_r, max_eff_s, num_iter_r;
  logic                err_r, sync_d1_r, sync_d2_r, sync_end_r;
  logic [PIPE_LAT-1:0] step_r;
  logic                wr_ena_r, busy_r, finish_r, converged_r, overrun_r, rd_lr_r, iter_0_r;
  logic                cnu_last_s, vnu_last_s, wr_clr_s, wr_set_s, beat_last_s, exit_s;
  logic                err_seen_s, enter_load_s, enter_cnu_s, enter_out_s, sync_rise_s;
  logic [1:0]          rd_cycle_s, wr_cycle_s;

  assign cnu_last_s   = state_r[S_CNU] && (cnt_r == CNU_LAST);
  assign vnu_last_s   = state_r[S_VNU] && (cnt_r == VNU_LAST);
  assign wr_clr_s     = state_r[S_VNU] && (cnt_r == WR_LAST);
  assign wr_set_s     = step_r[PIPE_LAT-1] & state_r[S_CNU];
  assign beat_last_s  = state_r[S_OUTPUT] && out_ready && (cnt_r == CNT_W'(out_last(rate_r)));
  assign err_seen_s   = err_r | parity_err;
  assign max_eff_s    = (max_r == '0) ? ITER_W'(1) : max_r;
  assign exit_s       = (num_iter_r == max_eff_s) || (early_term_en && !err_seen_s);
  assign sync_rise_s  = sync_in & ~sync_d1_r;
  assign enter_load_s = state_n_s[S_LOAD] & ~state_r[S_LOAD];
  assign enter_cnu_s  = state_n_s[S_CNU] & ~state_r[S_CNU];
  assign enter_out_s  = state_n_s[S_OUTPUT] & ~state_r[S_OUTPUT];

  // Frame sequencing FSM.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE:   if (sync_in) state_n_s = ST_LOAD; else state_n_s = ST_IDLE;
      ST_LOAD:   if (sync_end_r) state_n_s = ST_CNU; else state_n_s = ST_LOAD;
      ST_CNU:    if (cnu_last_s) state_n_s = ST_VNU; else state_n_s = ST_CNU;
      ST_VNU: begin
        if (vnu_last_s) state_n_s = exit_s ? ST_OUTPUT : ST_CNU;
        else            state_n_s = ST_VNU;
      end
      ST_OUTPUT: if (beat_last_s) state_n_s = ST_IDLE; else state_n_s = ST_OUTPUT;
      default:   state_n_s = ST_IDLE;
    endcase
  end

  // Phase counter runs through CNU+VNU and advances per accepted beat in OUTPUT.
  always_comb begin
    cnt_n_s = '0;
    if (state_r[S_CNU] || state_r[S_VNU]) begin
      if (vnu_last_s) cnt_n_s = '0;
      else            cnt_n_s = cnt_r + CNT_W'(1);
    end else if (state_r[S_OUTPUT]) begin
      if (beat_last_s)    cnt_n_s = '0;
      else if (out_ready) cnt_n_s = cnt_r + CNT_W'(1);
      else                cnt_n_s = cnt_r;
    end else begin
      cnt_n_s = '0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      rate_r      <= '0;
      max_r       <= '0;
      num_iter_r  <= '0;
      err_r       <= 1'b0;
      sync_d1_r   <= 1'b0;
      sync_d2_r   <= 1'b0;
      sync_end_r  <= 1'b0;
      step_r      <= '0;
      wr_ena_r    <= 1'b0;
      busy_r      <= 1'b0;
      finish_r    <= 1'b0;
      converged_r <= 1'b0;
      overrun_r   <= 1'b0;
      rd_lr_r     <= 1'b0;
      iter_0_r    <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      cnt_r      <= cnt_n_s;
      sync_d1_r  <= sync_in;
      sync_d2_r  <= sync_d1_r;
      sync_end_r <= sync_d2_r & ~sync_d1_r;
      step_r     <= {step_r[PIPE_LAT-2:0], rd_lq};
      finish_r   <= beat_last_s;
      rd_lr_r    <= state_r[S_CNU] & (num_iter_r != ITER_W'(1));
      iter_0_r   <= (num_iter_r == ITER_W'(1));
      if (enter_load_s) begin
        rate_r <= rate;
        max_r  <= max_iter;
      end
      if (enter_load_s)     num_iter_r <= '0;
      else if (enter_cnu_s) num_iter_r <= num_iter_r + ITER_W'(1);
      // A parity error coinciding with CNU entry must survive the clear.
      if (enter_load_s)     err_r <= 1'b0;
      else if (parity_err)  err_r <= 1'b1;
      else if (enter_cnu_s) err_r <= 1'b0;
      if (wr_clr_s)      wr_ena_r <= 1'b0;
      else if (wr_set_s) wr_ena_r <= 1'b1;
      if (state_r[S_LOAD] && sync_end_r) busy_r <= 1'b1;
      else if (beat_last_s)              busy_r <= 1'b0;
      if (enter_out_s) converged_r <= ~err_seen_s;
      if (enter_load_s)                           overrun_r <= 1'b0;
      else if (sync_rise_s && !state_r[S_IDLE])   overrun_r <= 1'b1;
    end
  end

  ldpc_phase_gen u_rd_phase (
    .clk     (clk),
    .reset_n (reset_n),
    .ena     (state_r[S_CNU]),
    .last    (cnu_last_s),
    .phase   (rd_cycle_s),
    .strobe  (rd_lq)
  );

  // The set term feeds the write generator directly so the first write
  // strobe lands PIPE_LAT+3 cycles after the first read strobe.
  ldpc_phase_gen u_wr_phase (
    .clk     (clk),
    .reset_n (reset_n),
    .ena     (wr_ena_r | wr_set_s),
    .last    (wr_clr_s),
    .phase   (wr_cycle_s),
    .strobe  (wr_lq)
  );

  assign fsm_state = state_r;
  assign cycle     = {rd_cycle_s, wr_cycle_s};
  assign wr_lr     = wr_ena_r;
  assign rd_lr     = rd_lr_r;
  assign iter_0    = iter_0_r;
  assign num_iter  = num_iter_r;
  assign busy      = busy_r;
  assign finish    = finish_r;
  assign out_valid = state_r[S_OUTPUT];
  assign converged = converged_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_ldpc_sched_ctrl.sv
// Scoreboard bench for ldpc_sched_ctrl: per-frame expectations are queued at
// stimulus time and compared against what the frame actually produced.
module tb_ldpc_sched_ctrl;
  import ldpc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, sync_in, early_term_en, parity_err, out_ready;
  logic [1:0] rate;
  logic [4:0] max_iter, fsm_state, num_iter;
  logic [3:0] cycle;
  logic       rd_lq, rd_lr, wr_lq, wr_lr, iter_0, busy, finish, out_valid, converged, overrun;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int   iters;
    int   beats;
    int   out_cycles;
    logic conv;
  } exp_t;

  typedef struct {
    int         iters, num_iter, beats, out_cycles, finishes, fin_gap, iter_len;
    int         load_lat, rd_lat, wr_lat;
    logic       conv, ovr_load, ovr_mid, ovr_end, iter0_first, rd_lr_first, idle_end, timeout;
    logic [4:0] st_mid;
  } res_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  ldpc_sched_ctrl dut (
    .clk(clk), .reset_n(reset_n), .sync_in(sync_in), .rate(rate), .max_iter(max_iter),
    .early_term_en(early_term_en), .parity_err(parity_err), .out_ready(out_ready),
    .fsm_state(fsm_state), .cycle(cycle), .rd_lq(rd_lq), .rd_lr(rd_lr), .wr_lq(wr_lq),
    .wr_lr(wr_lr), .iter_0(iter_0), .num_iter(num_iter), .busy(busy), .finish(finish),
    .out_valid(out_valid), .converged(converged), .overrun(overrun)
  );

  // Drive one frame and collect what the DUT did; all inputs change on negedges.
  task automatic run_frame(input logic [1:0] r, input logic [4:0] mi, input logic et,
                           input bit perr, input bit toggle, input bit ovr, output res_t res);
    int cyc, cnu_start, first_rd, last_beat;
    bit done, perr_sent;
    logic [4:0] prev;
    res = '{default: 0};
    cyc = 0; cnu_start = 0; first_rd = -1; last_beat = 0; done = 0; perr_sent = 0;
    @(negedge clk);
    rate = r; max_iter = mi; early_term_en = et; parity_err = 1'b0; out_ready = 1'b1;
    sync_in = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (fsm_state == ST_LOAD) res.ovr_load = overrun;
    end
    sync_in = 1'b0;
    prev = fsm_state;
    while (!done && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (fsm_state == ST_CNU && prev != ST_CNU) begin
        res.iters++;
        if (res.iters == 1) res.load_lat = cyc;
        if (res.iters == 2) res.iter_len = cyc - cnu_start;
        cnu_start = cyc;
        perr_sent = 0;
      end
      if (res.iters == 1 && cyc - cnu_start == 5) begin
        res.iter0_first = iter_0;
        res.rd_lr_first = rd_lr;
      end
      if (first_rd < 0 && rd_lq) begin
        first_rd = cyc;
        res.rd_lat = cyc - cnu_start;
      end
      if (res.wr_lat == 0 && first_rd >= 0 && wr_lq) res.wr_lat = cyc - first_rd;
      if (ovr && res.iters == 1) begin
        if (cyc - cnu_start == 100) sync_in = 1'b1;
        if (cyc - cnu_start == 102) sync_in = 1'b0;
        if (cyc - cnu_start == 106) begin
          res.ovr_mid = overrun;
          res.st_mid  = fsm_state;
        end
      end
      if (finish) begin
        res.finishes++;
        res.fin_gap = cyc - last_beat;
        done = 1;
      end
      if (out_valid && res.out_cycles == 0) res.num_iter = num_iter;
      parity_err = perr && (fsm_state == ST_VNU) && !perr_sent;
      if (parity_err) perr_sent = 1;
      out_ready = toggle ? ((res.out_cycles % 2) == 0) : 1'b1;
      if (out_valid) begin
        res.out_cycles++;
        if (out_ready) begin
          res.beats++;
          last_beat = cyc;
        end
      end
      prev = fsm_state;
    end
    res.timeout = !done;
    parity_err = 1'b0;
    out_ready = 1'b1;
    res.conv = converged;
    res.ovr_end = overrun;
    repeat (3) begin
      @(negedge clk);
      if (finish) res.finishes++;
    end
    res.idle_end = (fsm_state == ST_IDLE) && !busy;
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    reset_n = 1'b0; sync_in = 1'b0; rate = 2'd0; max_iter = 5'd0;
    early_term_en = 1'b0; parity_err = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    obs = {fsm_state, cycle, rd_lq, rd_lr, wr_lq, wr_lr, iter_0, num_iter,
           busy, finish, out_valid, converged, overrun};
    tests++;
    if (obs !== {5'b00001, 19'd0}) begin
      fails++; $display("FAIL reset_outputs: got %h expected %h", obs, {5'b00001, 19'd0});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (fsm_state !== ST_IDLE) begin
      fails++; $display("FAIL reset_idle_hold: got %b expected %b", fsm_state, ST_IDLE);
    end
  endtask

  task automatic test_max_iter();
    res_t r; exp_t e;
    sb_q.push_back('{iters: 3, beats: 4608, out_cycles: 4608, conv: 1'b1});
    run_frame(2'd0, 5'd3, 1'b0, 0, 0, 0, r);
    e = sb_q.pop_front();
    tests++; if (r.timeout !== 1'b0) begin fails++; $display("FAIL max_iter_timeout: got %0d expected 0", r.timeout); end
    tests++; if (r.iters !== e.iters) begin fails++; $display("FAIL max_iter_iters: got %0d expected %0d", r.iters, e.iters); end
    tests++; if (r.num_iter !== e.iters) begin fails++; $display("FAIL max_iter_num_iter: got %0d expected %0d", r.num_iter, e.iters); end
    tests++; if (r.beats !== e.beats) begin fails++; $display("FAIL max_iter_beats: got %0d expected %0d", r.beats, e.beats); end
    tests++; if (r.out_cycles !== e.out_cycles) begin fails++; $display("FAIL max_iter_out_cycles: got %0d expected %0d", r.out_cycles, e.out_cycles); end
    tests++; if (r.conv !== e.conv) begin fails++; $display("FAIL max_iter_converged: got %0d expected %0d", r.conv, e.conv); end
    tests++; if (r.finishes !== 1) begin fails++; $display("FAIL max_iter_finish_count: got %0d expected 1", r.finishes); end
    tests++; if (r.fin_gap !== 1) begin fails++; $display("FAIL max_iter_finish_gap: got %0d expected 1", r.fin_gap); end
    tests++; if (r.iter_len !== 779) begin fails++; $display("FAIL iter_length: got %0d expected 779", r.iter_len); end
    tests++; if (r.load_lat !== 3) begin fails++; $display("FAIL load_latency: got %0d expected 3", r.load_lat); end
    tests++; if (r.rd_lat !== 3) begin fails++; $display("FAIL first_rd_lq: got %0d expected 3", r.rd_lat); end
    tests++; if (r.wr_lat !== 10) begin fails++; $display("FAIL first_wr_lq: got %0d expected 10", r.wr_lat); end
    tests++; if ({r.iter0_first, r.rd_lr_first} !== 2'b10) begin fails++; $display("FAIL iter0_rd_lr: got %b expected 10", {r.iter0_first, r.rd_lr_first}); end
    tests++; if (r.idle_end !== 1'b1) begin fails++; $display("FAIL max_iter_idle_end: got %0d expected 1", r.idle_end); end
  endtask

  task automatic test_early_term();
    res_t r; exp_t e;
    sb_q.push_back('{iters: 1, beats: 6912, out_cycles: 6912, conv: 1'b1});
    run_frame(2'd2, 5'd5, 1'b1, 0, 0, 0, r);
    e = sb_q.pop_front();
    tests++; if (r.iters !== e.iters) begin fails++; $display("FAIL early_iters: got %0d expected %0d", r.iters, e.iters); end
    tests++; if (r.num_iter !== e.iters) begin fails++; $display("FAIL early_num_iter: got %0d expected %0d", r.num_iter, e.iters); end
    tests++; if (r.beats !== e.beats) begin fails++; $display("FAIL early_beats: got %0d expected %0d", r.beats, e.beats); end
    tests++; if (r.conv !== e.conv) begin fails++; $display("FAIL early_converged: got %0d expected %0d", r.conv, e.conv); end
    tests++; if (r.finishes !== 1) begin fails++; $display("FAIL early_finish_count: got %0d expected 1", r.finishes); end
  endtask

  task automatic test_parity_err();
    res_t r; exp_t e;
    sb_q.push_back('{iters: 5, beats: 4608, out_cycles: 4608, conv: 1'b0});
    run_frame(2'd0, 5'd5, 1'b1, 1, 0, 0, r);
    e = sb_q.pop_front();
    tests++; if (r.iters !== e.iters) begin fails++; $display("FAIL parity_iters: got %0d expected %0d", r.iters, e.iters); end
    tests++; if (r.num_iter !== e.iters) begin fails++; $display("FAIL parity_num_iter: got %0d expected %0d", r.num_iter, e.iters); end
    tests++; if (r.conv !== e.conv) begin fails++; $display("FAIL parity_converged: got %0d expected %0d", r.conv, e.conv); end
    tests++; if (r.beats !== e.beats) begin fails++; $display("FAIL parity_beats: got %0d expected %0d", r.beats, e.beats); end
  endtask

  task automatic test_backpressure();
    res_t r; exp_t e;
    sb_q.push_back('{iters: 1, beats: 5760, out_cycles: 11519, conv: 1'b1});
    run_frame(2'd1, 5'd1, 1'b0, 0, 1, 0, r);
    e = sb_q.pop_front();
    tests++; if (r.beats !== e.beats) begin fails++; $display("FAIL bp_beats: got %0d expected %0d", r.beats, e.beats); end
    tests++; if (r.out_cycles !== e.out_cycles) begin fails++; $display("FAIL bp_out_cycles: got %0d expected %0d", r.out_cycles, e.out_cycles); end
    tests++; if (r.fin_gap !== 1) begin fails++; $display("FAIL bp_finish_gap: got %0d expected 1", r.fin_gap); end
    tests++; if (r.finishes !== 1) begin fails++; $display("FAIL bp_finish_count: got %0d expected 1", r.finishes); end
  endtask

  task automatic test_overrun();
    res_t r; exp_t e;
    sb_q.push_back('{iters: 1, beats: 4608, out_cycles: 4608, conv: 1'b1});
    run_frame(2'd0, 5'd1, 1'b0, 0, 0, 1, r);
    e = sb_q.pop_front();
    tests++; if (r.ovr_mid !== 1'b1) begin fails++; $display("FAIL overrun_set: got %0d expected 1", r.ovr_mid); end
    tests++; if (r.st_mid !== ST_CNU) begin fails++; $display("FAIL overrun_state: got %b expected %b", r.st_mid, ST_CNU); end
    tests++; if (r.iters !== e.iters) begin fails++; $display("FAIL overrun_iters: got %0d expected %0d", r.iters, e.iters); end
    tests++; if (r.beats !== e.beats) begin fails++; $display("FAIL overrun_beats: got %0d expected %0d", r.beats, e.beats); end
    tests++; if (r.ovr_end !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %0d expected 1", r.ovr_end); end
    // max_iter of 0 behaves as a single iteration.
    sb_q.push_back('{iters: 1, beats: 7680, out_cycles: 7680, conv: 1'b1});
    run_frame(2'd3, 5'd0, 1'b0, 0, 0, 0, r);
    e = sb_q.pop_front();
    tests++; if (r.ovr_load !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %0d expected 0", r.ovr_load); end
    tests++; if (r.iters !== e.iters) begin fails++; $display("FAIL max0_iters: got %0d expected %0d", r.iters, e.iters); end
    tests++; if (r.beats !== e.beats) begin fails++; $display("FAIL rate3_beats: got %0d expected %0d", r.beats, e.beats); end
  endtask

  task automatic test_async_reset();
    res_t r; exp_t e;
    int cyc, n;
    bit hit, fin_seen;
    logic [4:0] prev;
    logic [23:0] obs;
    cyc = 0; n = 0; hit = 0; fin_seen = 0;
    @(negedge clk);
    rate = 2'd0; max_iter = 5'd3; early_term_en = 1'b0; sync_in = 1'b1;
    repeat (4) @(negedge clk);
    sync_in = 1'b0;
    prev = fsm_state;
    while (!hit && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (fsm_state == ST_CNU && prev != ST_CNU) n++;
      if (n == 2 && fsm_state == ST_VNU) hit = 1;
      prev = fsm_state;
    end
    tests++; if (hit !== 1'b1) begin fails++; $display("FAIL areset_reach_vnu2: got %0d expected 1", hit); end
    #2 reset_n = 1'b0;
    #1;
    obs = {fsm_state, cycle, rd_lq, rd_lr, wr_lq, wr_lr, iter_0, num_iter,
           busy, finish, out_valid, converged, overrun};
    tests++;
    if (obs !== {5'b00001, 19'd0}) begin
      fails++; $display("FAIL areset_outputs: got %h expected %h", obs, {5'b00001, 19'd0});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (finish) fin_seen = 1;
    end
    tests++; if ({fin_seen, fsm_state} !== {1'b0, ST_IDLE}) begin fails++; $display("FAIL areset_idle: got %b expected %b", {fin_seen, fsm_state}, {1'b0, ST_IDLE}); end
    sb_q.push_back('{iters: 2, beats: 4608, out_cycles: 4608, conv: 1'b1});
    run_frame(2'd0, 5'd2, 1'b0, 0, 0, 0, r);
    e = sb_q.pop_front();
    tests++; if (r.iters !== e.iters) begin fails++; $display("FAIL areset_iters: got %0d expected %0d", r.iters, e.iters); end
    tests++; if (r.beats !== e.beats) begin fails++; $display("FAIL areset_beats: got %0d expected %0d", r.beats, e.beats); end
    tests++; if (r.finishes !== 1) begin fails++; $display("FAIL areset_finish_count: got %0d expected 1", r.finishes); end
  endtask

  initial begin
    test_reset();
    test_max_iter();
    test_early_term();
    test_parity_err();
    test_backpressure();
    test_overrun();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
